led_scan_scheduler: RTL and testbench

Scan scheduler for the 8x8 LED / 7-segment Pmod driven through a 16-bit 74HC595 chain. It owns a double-buffered 8x8 frame of 2-bit brightness levels and sequences 32 line words per frame (4 density subframes × 8 rows). Each line word is handed over a valid/ready link to a serializer that drives `sclk`, `rclk`, `_srclr` and `serial_data`. Host writes go only to the back buffer; buffer swaps take effect at frame boundaries, so a displayed frame never tears.

---
 rtl/led_scan_pkg.sv | 33 +++
 rtl/hc595_shifter.sv | 108 ++++++++++
 rtl/led_scan_scheduler.sv | 109 ++++++++++
 tb/tb_led_scan_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED scan scheduler and its 74HC595 serializer.
package led_scan_pkg;

    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int SUBFRAMES = 4;
    localparam int LINE_W    = 16;

    typedef logic [1:0]            level_t;
    typedef logic [LINE_W-1:0]     line_t;
    typedef level_t [COLS-1:0]     row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } shift_state_t;

    // Row select is active low in the upper byte; a column is lit while its level exceeds the subframe.
    function automatic line_t build_line(input logic [2:0] row, input logic [1:0] sf,
                                         input row_t lv, input logic blank_i);
        line_t w;
        w[15:8] = ~(8'd1 << row);
        for (int i = 0; i < COLS; i++) begin
            w[i] = (lv[i] > sf);
        end
        if (blank_i) begin
            w = 16'hFF00;
        end
        return w;
    endfunction

endpackage

// File: rtl/hc595_shifter.sv
// Serializer for one 16-bit line word: 32 half-period ticks of sclk, then a latch pulse on rclk.
module hc595_shifter
    import led_scan_pkg::*;
#(
    parameter int SCLK_DIV = 801
) (
    input  logic  clk,
    input  logic  _rst,
    input  line_t line_data,
    input  logic  line_valid,
    output logic  line_ready,
    output logic  sclk,
    output logic  rclk,
    output logic  serial_data
);

    localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCLK_DIV - 1);

    shift_state_t     r_state, w_state_n;
    logic [DIV_W-1:0] r_div, w_div_n;
    logic [5:0]       r_cnt, w_cnt_n;
    line_t            r_sh, w_sh_n;
    logic             r_sclk, w_sclk_n;
    logic             r_rclk, w_rclk_n;
    logic             r_sd, w_sd_n;
    logic             w_tick;

    always_ff @(posedge clk) begin
        if (!_rst) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_sclk  <= 1'b0;
            r_rclk  <= 1'b0;
            r_sd    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_cnt   <= w_cnt_n;
            r_sh    <= w_sh_n;
            r_sclk  <= w_sclk_n;
            r_rclk  <= w_rclk_n;
            r_sd    <= w_sd_n;
        end
    end

    // r_cnt holds the number of ticks already taken, so the current tick number is r_cnt+1.
    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_cnt_n   = r_cnt;
        w_sh_n    = r_sh;
        w_sclk_n  = r_sclk;
        w_rclk_n  = r_rclk;
        w_sd_n    = r_sd;
        w_tick    = (r_div == DIV_MAX);
        case (r_state)
            IDLE: begin
                if (line_valid) begin
                    w_state_n = SHIFT;
                    w_div_n   = '0;
                    w_cnt_n   = '0;
                    w_sh_n    = line_data;
                end
            end
            SHIFT: begin
                w_div_n = w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    w_cnt_n = r_cnt + 6'd1;
                    if (!r_cnt[0]) begin
                        w_sd_n   = r_sh[LINE_W-1];
                        w_sh_n   = {r_sh[LINE_W-2:0], 1'b0};
                        w_sclk_n = 1'b0;
                    end else begin
                        w_sclk_n = 1'b1;
                    end
                    if (r_cnt == 6'd31) begin
                        w_state_n = LATCH;
                    end
                end
            end
            LATCH: begin
                w_div_n = w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    w_cnt_n = r_cnt + 6'd1;
                    if (r_cnt == 6'd32) begin
                        w_sclk_n = 1'b0;
                        w_rclk_n = 1'b1;
                    end else begin
                        w_rclk_n  = 1'b0;
                        w_state_n = IDLE;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign line_ready  = (r_state == IDLE);
    assign sclk        = r_sclk;
    assign rclk        = r_rclk;
    assign serial_data = r_sd;

endmodule

// File: rtl/led_scan_scheduler.sv
// Double-buffered 8x8 2-bit frame scanned as 32 line words per frame; swaps only at frame boundaries.
module led_scan_scheduler
    import led_scan_pkg::*;
#(
    parameter int SCLK_DIV = 801
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [2:0] wr_col,
    input  level_t     wr_level,
    input  logic       swap_req,
    input  logic       blank,
    output logic       swap_pending,
    output logic       swap_ack,
    output logic       frame_start,
    output logic       sclk,
    output logic       rclk,
    output logic       _srclr,
    output logic       serial_data
);

    row_t       r_buf0 [ROWS];
    row_t       r_buf1 [ROWS];
    logic       r_sel;
    logic [4:0] r_li;
    line_t      r_line;
    logic       r_valid;
    logic       r_pend;
    logic       r_ack;
    logic       r_fs;
    logic       r_srclr;

    logic       w_ready;
    logic       w_accept;
    logic       w_do_swap;
    logic [2:0] w_row;
    logic [1:0] w_sf;
    row_t       w_front_row;

    assign w_row       = r_li[2:0];
    assign w_sf        = r_li[4:3];
    assign w_front_row = r_sel ? r_buf1[w_row] : r_buf0[w_row];
    assign w_accept    = r_valid & w_ready;
    assign w_do_swap   = w_accept & (r_li == 5'd31) & (r_pend | swap_req);

    // r_li indexes the word held in r_line; it moves on at acceptance and the next word is built one cycle later.
    always_ff @(posedge clk) begin
        if (!_rst) begin
            for (int r = 0; r < ROWS; r++) begin
                r_buf0[r] <= '0;
                r_buf1[r] <= '0;
            end
            r_sel   <= 1'b0;
            r_li    <= '0;
            r_line  <= '0;
            r_valid <= 1'b0;
            r_pend  <= 1'b0;
            r_ack   <= 1'b0;
            r_fs    <= 1'b0;
            r_srclr <= 1'b0;
        end else begin
            r_srclr <= 1'b1;
            r_ack   <= w_do_swap;
            r_fs    <= w_accept & (r_li == 5'd0);
            if (w_accept) begin
                r_li    <= r_li + 5'd1;
                r_valid <= 1'b0;
            end else if (!r_valid) begin
                r_line  <= build_line(w_row, w_sf, w_front_row, blank);
                r_valid <= 1'b1;
            end
            if (w_do_swap) begin
                r_sel  <= ~r_sel;
                r_pend <= 1'b0;
            end else if (swap_req) begin
                r_pend <= 1'b1;
            end
            // Writes use the pre-swap select, so a write in the swap cycle lands in the new front.
            if (wr_en) begin
                if (r_sel) begin
                    r_buf0[wr_row][wr_col] <= wr_level;
                end else begin
                    r_buf1[wr_row][wr_col] <= wr_level;
                end
            end
        end
    end

    hc595_shifter #(
        .SCLK_DIV(SCLK_DIV)
    ) u_shifter (
        .clk        (clk),
        ._rst       (_rst),
        .line_data  (r_line),
        .line_valid (r_valid),
        .line_ready (w_ready),
        .sclk       (sclk),
        .rclk       (rclk),
        .serial_data(serial_data)
    );

    assign swap_pending = r_pend;
    assign swap_ack     = r_ack;
    assign frame_start  = r_fs;
    assign _srclr       = r_srclr;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Self-checking bench: timing-based frame model plus a serial-stream decoder compared every cycle.
module tb_led_scan_scheduler;

    localparam int SD = 2;
    localparam int LP = 34 * SD + 1;
    localparam int FP = 32 * LP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = 3'd0;
    logic [2:0] wr_col = 3'd0;
    logic [1:0] wr_level = 2'd0;
    logic       swap_req = 1'b0;
    logic       blank = 1'b0;
    logic       swap_pending, swap_ack, frame_start, sclk, rclk, srclr_n, serial_data;

    led_scan_scheduler #(.SCLK_DIV(SD)) dut (
        .clk         (clk),
        ._rst        (rst_n),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_level    (wr_level),
        .swap_req    (swap_req),
        .blank       (blank),
        .swap_pending(swap_pending),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .sclk        (sclk),
        .rclk        (rclk),
        ._srclr      (srclr_n),
        .serial_data (serial_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lines are accepted every LP cycles starting at the second edge after reset.
    logic [1:0]  m_front [8][8];
    logic [1:0]  m_back  [8][8];
    int          m_e = 0;
    bit          m_init = 0, m_pend = 0, m_ack = 0, m_fs = 0;
    logic [15:0] m_q [$];

    always @(posedge clk) begin : model
        int n, li;
        bit acc, bnd, bld;
        logic [15:0] w;
        logic [1:0] t;
        if (!rst_n) begin
            m_init = 1;
            m_e = 0;
            m_pend = 0;
            m_ack = 0;
            m_fs = 0;
            m_q.delete();
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    m_front[r][c] = 2'd0;
                    m_back[r][c] = 2'd0;
                end
        end else begin
            m_e = m_e + 1;
            acc = (m_e >= 2) && ((m_e - 2) % LP == 0);
            n = (m_e >= 2) ? (m_e - 2) / LP : 0;
            bnd = acc && (n % 32 == 31);
            bld = (m_e == 1) || ((m_e >= 3) && ((m_e - 3) % LP == 0));
            if (bld) begin
                li = (m_e == 1) ? 0 : (((m_e - 3) / LP) + 1) % 32;
                w = {~(8'h01 << (li % 8)), 8'h00};
                for (int c = 0; c < 8; c++)
                    if (int'(m_front[li % 8][c]) > li / 8) w[c] = 1'b1;
                if (blank) w = 16'hFF00;
                m_q.push_back(w);
            end
            if (wr_en) m_back[wr_row][wr_col] = wr_level;
            if (bnd && (m_pend || swap_req)) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        t = m_front[r][c];
                        m_front[r][c] = m_back[r][c];
                        m_back[r][c] = t;
                    end
                m_ack = 1;
                m_pend = 0;
            end else begin
                m_ack = 0;
                if (swap_req) m_pend = 1;
            end
            m_fs = acc && (n % 32 == 0);
        end
    end

    logic [15:0] d_sh = 16'h0;
    int          d_rise = 0, d_since = 0, d_rhigh = 0, rd_idx = 0;
    bit          d_prev = 0, p_sclk = 0, p_rclk = 0;
    logic [15:0] got_words [$];

    task automatic cyc();
        @(negedge clk);
        if (m_init) begin
            checks++;
            if (swap_ack !== m_ack) begin
                errors++;
                $display("FAIL swap_ack got %b exp %b at %0t", swap_ack, m_ack, $time);
            end
            checks++;
            if (frame_start !== m_fs) begin
                errors++;
                $display("FAIL frame_start got %b exp %b at %0t", frame_start, m_fs, $time);
            end
            checks++;
            if (swap_pending !== m_pend) begin
                errors++;
                $display("FAIL swap_pending got %b exp %b at %0t", swap_pending, m_pend, $time);
            end
            checks++;
            if (srclr_n !== (m_e >= 1)) begin
                errors++;
                $display("FAIL srclr got %b exp %b at %0t", srclr_n, (m_e >= 1), $time);
            end
            if (m_e == 0) begin
                checks++;
                if ({sclk, rclk, serial_data} !== 3'b000) begin
                    errors++;
                    $display("FAIL reset_lines got %b exp 000 at %0t", {sclk, rclk, serial_data}, $time);
                end
                d_sh = 16'h0; d_rise = 0; d_since = 0; d_rhigh = 0; rd_idx = 0;
                d_prev = 0; p_sclk = 0; p_rclk = 0;
            end else begin
                d_since++;
                if (sclk && !p_sclk) begin
                    d_sh = {d_sh[14:0], serial_data};
                    d_rise++;
                end
                if (rclk && !p_rclk) begin
                    checks++;
                    if (d_rise != 16) begin
                        errors++;
                        $display("FAIL sclk_rises got %0d exp 16 at %0t", d_rise, $time);
                    end
                    checks++;
                    if (rd_idx >= m_q.size()) begin
                        errors++;
                        $display("FAIL word got %h exp none at %0t", d_sh, $time);
                    end else if (d_sh !== m_q[rd_idx]) begin
                        errors++;
                        $display("FAIL word got %h exp %h at %0t", d_sh, m_q[rd_idx], $time);
                    end
                    rd_idx++;
                    got_words.push_back(d_sh);
                    if (d_prev) begin
                        checks++;
                        if (d_since != LP) begin
                            errors++;
                            $display("FAIL line_period got %0d exp %0d at %0t", d_since, LP, $time);
                        end
                    end
                    d_prev = 1; d_since = 0; d_rise = 0;
                end
                if (rclk) d_rhigh++;
                if (!rclk && p_rclk) begin
                    checks++;
                    if (d_rhigh != SD) begin
                        errors++;
                        $display("FAIL rclk_width got %0d exp %0d at %0t", d_rhigh, SD, $time);
                    end
                    d_rhigh = 0;
                end
                p_sclk = sclk;
                p_rclk = rclk;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run(3);
        checks++;
        if ({sclk, rclk, serial_data, srclr_n, swap_ack, frame_start, swap_pending} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0000000",
                     {sclk, rclk, serial_data, srclr_n, swap_ack, frame_start, swap_pending});
        end
        rst_n = 1'b1;
        got_words.delete();
        run(2 * LP + 6);
        checks++;
        if (got_words.size() < 2 || got_words[0] !== 16'hFE00) begin
            errors++;
            $display("FAIL first_word got %h exp fe00 (n=%0d)",
                     (got_words.size() > 0) ? got_words[0] : 16'hxxxx, got_words.size());
        end
    endtask

    task automatic wait_ack(input string name);
        bit seen = 0;
        for (int i = 0; i < FP + LP && !seen; i++) begin
            cyc();
            if (swap_ack === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_ack got none exp pulse", name);
        end
    endtask

    task automatic count_words(input logic [15:0] pat, input logic [15:0] mask,
                               output int hits, output int lit);
        hits = 0;
        lit = 0;
        foreach (got_words[i]) begin
            if ((got_words[i] & mask) === pat) hits++;
            if (got_words[i][7:0] !== 8'h00) lit++;
        end
    endtask

    task automatic test_swap_row2();
        int hits, lit;
        cyc();
        wr_en = 1; wr_row = 3'd2; wr_col = 3'd5; wr_level = 2'd3;
        cyc();
        wr_en = 0; swap_req = 1;
        cyc();
        swap_req = 0;
        got_words.delete();
        wait_ack("row2");
        count_words(16'h0000, 16'h0000, hits, lit);
        checks++;
        if (lit != 0) begin
            errors++;
            $display("FAIL pre_swap_lit got %0d exp 0", lit);
        end
        got_words.delete();
        run(FP + LP);
        count_words(16'hFB20, 16'hFFFF, hits, lit);
        checks++;
        if (hits != 3 || lit != 3) begin
            errors++;
            $display("FAIL row2_words got %0d/%0d exp 3/3", hits, lit);
        end
    endtask

    task automatic test_level1();
        int hits, lit;
        wr_en = 1; wr_row = 3'd0; wr_col = 3'd0; wr_level = 2'd1;
        cyc();
        wr_en = 0; swap_req = 1;
        cyc();
        swap_req = 0;
        wait_ack("level1");
        got_words.delete();
        run(FP + LP);
        count_words(16'hFE01, 16'hFFFF, hits, lit);
        checks++;
        if (hits != 1 || lit != 1) begin
            errors++;
            $display("FAIL level1_words got %0d/%0d exp 1/1", hits, lit);
        end
    endtask

    task automatic test_multi_swap();
        bit seen = 0;
        int acks = 0;
        for (int i = 0; i < FP + LP && !seen; i++) begin
            cyc();
            if (frame_start === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL multi_fs got none exp pulse");
        end
        for (int k = 0; k < 3; k++) begin
            run(50);
            swap_req = 1;
            cyc();
            swap_req = 0;
            checks++;
            if (swap_pending !== 1'b1) begin
                errors++;
                $display("FAIL multi_pending got %b exp 1", swap_pending);
            end
        end
        for (int i = 0; i < FP + LP; i++) begin
            cyc();
            if (swap_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 1 || swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL multi_acks got %0d pend %b exp 1 pend 0", acks, swap_pending);
        end
    endtask

    task automatic test_swap_at_boundary();
        bit found = 0;
        checks++;
        if (swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL bnd_pre_pending got %b exp 0", swap_pending);
        end
        for (int i = 0; i < FP + LP && !found; i++) begin
            if ((m_e + 1 >= 2) && ((m_e - 1) % LP == 0) && (((m_e - 1) / LP) % 32 == 31)) found = 1;
            else cyc();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bnd_search got none exp boundary");
        end
        swap_req = 1;
        wr_en = 1; wr_row = 3'd7; wr_col = 3'd7; wr_level = 2'd2;
        cyc();
        swap_req = 0;
        wr_en = 0;
        checks++;
        if (swap_ack !== 1'b1 || swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL bnd_swap got ack %b pend %b exp ack 1 pend 0", swap_ack, swap_pending);
        end
        run(FP + LP);
    endtask

    task automatic test_blank();
        int ok = 0, lit = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                wr_en = 1; wr_row = 3'(r); wr_col = 3'(c); wr_level = 2'd3;
                cyc();
            end
        wr_en = 0; swap_req = 1;
        cyc();
        swap_req = 0;
        wait_ack("blank");
        blank = 1;
        got_words.delete();
        run(FP + 2 * LP);
        for (int i = 1; i < got_words.size(); i++)
            if (got_words[i] === 16'hFF00) ok++;
        checks++;
        if (got_words.size() < 33 || ok != got_words.size() - 1) begin
            errors++;
            $display("FAIL blank_words got %0d of %0d exp all", ok, got_words.size() - 1);
        end
        blank = 0;
        got_words.delete();
        run(FP + 2 * LP);
        for (int i = 1; i < 33 && i < got_words.size(); i++)
            if (got_words[i][7:0] === 8'hFF && got_words[i][15:8] !== 8'hFF) lit++;
        checks++;
        if (lit != 24) begin
            errors++;
            $display("FAIL unblank_words got %0d exp 24", lit);
        end
    endtask

    task automatic test_random();
        got_words.delete();
        for (int i = 0; i < 3 * FP; i++) begin
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_row   = 3'($urandom_range(0, 7));
            wr_col   = 3'($urandom_range(0, 7));
            wr_level = 2'($urandom_range(0, 3));
            swap_req = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 299) == 0) blank = ~blank;
            cyc();
        end
        wr_en = 0; swap_req = 0; blank = 0;
        checks++;
        if (got_words.size() < 90) begin
            errors++;
            $display("FAIL random_words got %0d exp >=90", got_words.size());
        end
    endtask

    task automatic test_reset_midline();
        bit found = 0, seen = 0;
        for (int i = 0; i < 2 * LP && !found; i++) begin
            cyc();
            if ((m_e >= 2) && ((m_e - 2) % LP == 0)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_accept got none exp accept");
        end
        run(10 * SD - 1);
        rst_n = 1'b0;
        cyc();
        checks++;
        if ({sclk, rclk, serial_data, srclr_n} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset got %b exp 0000", {sclk, rclk, serial_data, srclr_n});
        end
        rst_n = 1'b1;
        got_words.delete();
        for (int i = 0; i < 6 && !seen; i++) begin
            cyc();
            if (frame_start === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_frame_start got none exp pulse");
        end
        run(2 * LP);
        checks++;
        if (got_words.size() < 1 || got_words[0] !== 16'hFE00) begin
            errors++;
            $display("FAIL mid_first_word got %h exp fe00",
                     (got_words.size() > 0) ? got_words[0] : 16'hxxxx);
        end
    endtask

    initial begin
        test_reset();
        test_swap_row2();
        test_level1();
        test_multi_swap();
        test_swap_at_boundary();
        test_blank();
        test_random();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
